mult_share_sched: RTL and testbench

Shares one pipelined unsigned multiplier between NUM_REQ requesters. A round-robin scheduler admits one request per cycle and tags it with the requester index. Products travel a STAGES-deep enabled register pipe, and each result returns to its owner through a per-requester valid/ready response port. The block sits between several datapath clients and a single multiplier resource; it owns sequencing, occupancy accounting and backpressure.

---
 rtl/mult_share_sched_pkg.sv | 19 +
 rtl/mult_share_sched_if.sv | 34 +++
 rtl/mult_share_sched_rr_arbiter.sv | 50 +++++
 rtl/mult_share_sched.sv | 114 +++++++++++
 tb/tb_mult_share_sched.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_sched_pkg.sv
// Shared width helpers for the multiplier-sharing scheduler.
package mult_share_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int id_width(input int num_req);
    return (clog2(num_req) < 1) ? 1 : clog2(num_req);
  endfunction

  function automatic int cen_width(input int stages);
    return clog2(stages + 1);
  endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Request/response bundle between the clients (master) and the shared multiplier scheduler (slave).
interface mult_share_sched_if
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int STAGES  = 4
) ();
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CEN_W = cen_width(STAGES);
  localparam int P_W   = A_WIDTH + B_WIDTH;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [P_W-1:0]             rsp_product;
  logic [ID_W-1:0]            rsp_id;
  logic [CEN_W-1:0]           pipe_census;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, pipe_census, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, pipe_census, busy
  );
endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester after the last one served.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o
);
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] above_ptr;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick_src;
  logic [ID_W-1:0]    id_chain [NUM_REQ+1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign above_ptr[gi] = (ID_W'(gi) > ptr_q);
    end
  endgenerate

  // Requesters above ptr win first; if none, wrap around to the lowest index.
  assign req_hi   = req_i & above_ptr;
  assign pick_src = (|req_hi) ? req_hi : req_i;
  assign grant_o  = pick_src & (~pick_src + NUM_REQ'(1));

  assign id_chain[0] = '0;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_id
      assign id_chain[gi+1] = id_chain[gi] | (grant_o[gi] ? ID_W'(gi) : '0);
    end
  endgenerate
  assign grant_id_o = id_chain[NUM_REQ];

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (|req_i)) ptr_d = grant_id_o;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= ID_W'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mult_share_sched.sv
// Shares one STAGES-deep pipelined multiplier among NUM_REQ clients with round-robin issue
// and per-client response steering; the whole pipe stalls when the head is not accepted.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int STAGES  = 4
) (
  input logic              clk,
  input logic              rst,
  mult_share_sched_if.slave bus
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CEN_W = cen_width(STAGES);
  localparam int P_W   = A_WIDTH + B_WIDTH;

  logic              v_q    [STAGES];
  logic [ID_W-1:0]   id_q   [STAGES];
  logic [P_W-1:0]    data_q [STAGES];
  logic [CEN_W-1:0]  cen_q, cen_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] head_owner;
  logic [NUM_REQ-1:0] req_ready_int;
  logic               adv, issue, retire;
  logic [A_WIDTH-1:0] a_chain [NUM_REQ+1];
  logic [B_WIDTH-1:0] b_chain [NUM_REQ+1];
  logic [P_W-1:0]     issue_prod;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign head_owner[gi] = v_q[STAGES-1] & (id_q[STAGES-1] == ID_W'(gi));
    end
  endgenerate

  // Only the head owner's ready matters; an empty head always lets the pipe move.
  assign retire = |(head_owner & bus.rsp_ready);
  assign adv    = !v_q[STAGES-1] | retire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (bus.req_valid),
    .adv_i      (adv & !rst),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req_ready_int = (adv && !rst) ? grant : '0;
  assign issue         = |(bus.req_valid & req_ready_int);

  assign a_chain[0] = '0;
  assign b_chain[0] = '0;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_opmux
      assign a_chain[gi+1] = a_chain[gi] | (grant[gi] ? bus.req_a[gi*A_WIDTH +: A_WIDTH] : '0);
      assign b_chain[gi+1] = b_chain[gi] | (grant[gi] ? bus.req_b[gi*B_WIDTH +: B_WIDTH] : '0);
    end
  endgenerate
  assign issue_prod = P_W'(a_chain[NUM_REQ]) * P_W'(b_chain[NUM_REQ]);

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head_in
        always_ff @(posedge clk) begin
          if (rst) begin
            v_q[0]    <= 1'b0;
            id_q[0]   <= '0;
            data_q[0] <= '0;
          end else if (adv) begin
            v_q[0]    <= issue;
            id_q[0]   <= grant_id;
            data_q[0] <= issue_prod;
          end
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (rst) begin
            v_q[gi]    <= 1'b0;
            id_q[gi]   <= '0;
            data_q[gi] <= '0;
          end else if (adv) begin
            v_q[gi]    <= v_q[gi-1];
            id_q[gi]   <= id_q[gi-1];
            data_q[gi] <= data_q[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    cen_d = cen_q;
    if (issue && !retire)      cen_d = cen_q + CEN_W'(1);
    else if (retire && !issue) cen_d = cen_q - CEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cen_q <= '0;
    else     cen_q <= cen_d;
  end

  // Outputs are forced quiet while reset is held, before the registers have cleared.
  assign bus.req_ready   = req_ready_int;
  assign bus.rsp_valid   = rst ? '0 : head_owner;
  assign bus.rsp_product = rst ? '0 : data_q[STAGES-1];
  assign bus.rsp_id      = rst ? '0 : id_q[STAGES-1];
  assign bus.pipe_census = rst ? '0 : cen_q;
  assign bus.busy        = !rst && (cen_q != '0);
endmodule

// File: tb/tb_mult_share_sched.sv
// Directed + random bench for mult_share_sched against a cycle-level delay-line model and an issue-order scoreboard.
module tb_mult_share_sched;
  localparam int N = 4;
  localparam int S = 4;

  logic clk;
  logic rst;

  mult_share_sched_if #(.NUM_REQ(N), .A_WIDTH(8), .B_WIDTH(8), .STAGES(S)) bus ();

  mult_share_sched #(.NUM_REQ(N), .A_WIDTH(8), .B_WIDTH(8), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] prod;
  } exp_t;

  int n_checks = 0;
  int n_err    = 0;

  // Model: a delay line of S slots (slot S-1 = presented result) plus last-served pointer.
  logic        m_v    [S];
  logic [1:0]  m_id   [S];
  logic [15:0] m_data [S];
  int          m_ptr;
  exp_t        sb[$];

  logic [3:0]  obs_rsp_valid;
  logic [3:0]  obs_req_ready;
  logic [15:0] obs_prod;
  logic [2:0]  obs_census;
  int          n_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] rv, input logic [3:0] rr,
                       input logic [31:0] av, input logic [31:0] bv, input logic r);
    logic       head_v, adv;
    int         g, cnt;
    logic [3:0] exp_rv, exp_rdy;
    logic [15:0] prod;
    exp_t       e;
    bus.req_valid = rv;
    bus.rsp_ready = rr;
    bus.req_a     = av;
    bus.req_b     = bv;
    rst           = r;
    @(negedge clk);
    head_v = m_v[S-1];
    adv    = !head_v || rr[m_id[S-1]];
    g = -1;
    for (int off = 1; off <= N; off++) begin
      if (g < 0 && rv[(m_ptr + off) % N]) g = (m_ptr + off) % N;
    end
    exp_rv  = '0;
    exp_rdy = '0;
    cnt     = 0;
    if (!r) begin
      if (head_v) exp_rv[m_id[S-1]] = 1'b1;
      if (adv && g >= 0) exp_rdy[g] = 1'b1;
      for (int k = 0; k < S; k++) cnt += int'(m_v[k]);
    end
    obs_rsp_valid = bus.rsp_valid;
    obs_req_ready = bus.req_ready;
    obs_prod      = bus.rsp_product;
    obs_census    = bus.pipe_census;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("census", 32'(bus.pipe_census), 32'(cnt));
    check("busy", 32'(bus.busy), 32'(cnt != 0));
    if (r) begin
      check("rst_product", 32'(bus.rsp_product), 32'd0);
      check("rst_id", 32'(bus.rsp_id), 32'd0);
    end else if (head_v) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id[S-1]));
      check("rsp_product", 32'(bus.rsp_product), 32'(m_data[S-1]));
      if (rr[m_id[S-1]]) begin
        n_checks++;
        assert (sb.size() != 0)
        else begin
          n_err++;
          $error("FAIL sb_underflow observed=retire expected=none");
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_id", 32'(bus.rsp_id), 32'(e.id));
          check("sb_product", 32'(bus.rsp_product), 32'(e.prod));
          n_retired++;
        end
      end
    end
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < S; k++) begin
        m_v[k] = 1'b0; m_id[k] = '0; m_data[k] = '0;
      end
      m_ptr = N - 1;
      sb.delete();
    end else if (adv) begin
      for (int k = S - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_id[k] = m_id[k-1]; m_data[k] = m_data[k-1];
      end
      m_v[0] = (g >= 0);
      m_id[0] = 2'(g < 0 ? 0 : g);
      prod = '0;
      if (g >= 0) begin
        prod  = 16'(av[g*8 +: 8]) * 16'(bv[g*8 +: 8]);
        m_ptr = g;
        sb.push_back('{id: 2'(g), prod: prod});
      end
      m_data[0] = prod;
    end
    #1;
  endtask

  initial begin
    int lat;
    logic [2:0] cen_seq [8];
    logic [31:0] ra, rb;
    bit seen_ff;
    for (int k = 0; k < S; k++) begin
      m_v[k] = 1'b0; m_id[k] = '0; m_data[k] = '0;
    end
    m_ptr = N - 1;
    n_retired = 0;
    rst = 1'b1;
    bus.req_valid = '0; bus.rsp_ready = '0; bus.req_a = '0; bus.req_b = '0;

    // Reset with requests pending: nothing admitted, everything quiet.
    cycle(4'hF, 4'hF, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    cycle(4'hF, 4'hF, 32'h12345678, 32'h9ABCDEF0, 1'b1);

    // Single request from requester 2: 200*3 with four-cycle latency.
    cycle(4'b0100, 4'hF, 32'(200) << 16, 32'(3) << 16, 1'b0);
    check("single_ready", 32'(obs_req_ready), 32'h4);
    lat = -1;
    for (int k = 1; k <= 7; k++) begin
      cycle(4'b0000, 4'hF, 32'h0, 32'h0, 1'b0);
      cen_seq[k] = obs_census;
      if (lat < 0 && obs_rsp_valid[2]) begin
        lat = k;
        check("single_product", 32'(obs_prod), 32'd600);
      end
    end
    check("single_latency", 32'(lat), 32'd4);
    check("cen_step1", 32'(cen_seq[1]), 32'd1);
    check("cen_step2", 32'(cen_seq[2]), 32'd1);
    check("cen_step3", 32'(cen_seq[3]), 32'd1);
    check("cen_step4", 32'(cen_seq[4]), 32'd1);
    check("cen_step5", 32'(cen_seq[5]), 32'd0);

    // All requesters continuously valid: strict rotation 3,0,1,2,... (last served was 2).
    for (int k = 0; k < 16; k++) begin
      cycle(4'hF, 4'hF, $urandom, $urandom, 1'b0);
      check("rr_order", 32'(obs_req_ready), 32'(1) << ((3 + k) % N));
    end
    check("saturated_census", 32'(obs_census), 32'd4);

    // Full pipe, head not accepted for 5 cycles: no admits, then resume.
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 4'h0, $urandom, $urandom, 1'b0);
      check("stall_ready", 32'(obs_req_ready), 32'd0);
    end
    for (int k = 0; k < 8; k++) cycle(4'hF, 4'hF, $urandom, $urandom, 1'b0);
    for (int k = 0; k < 6; k++) cycle(4'h0, 4'hF, 32'h0, 32'h0, 1'b0);

    // Operand extremes: FF*FF on requester 1, 0*FF on requester 3.
    cycle(4'b0010, 4'hF, 32'h0000FF00, 32'h0000FF00, 1'b0);
    cycle(4'b1000, 4'hF, 32'h00000000, 32'hFF000000, 1'b0);
    seen_ff = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(4'h0, 4'hF, 32'h0, 32'h0, 1'b0);
      if (obs_rsp_valid[1]) begin
        check("max_product", 32'(obs_prod), 32'hFE01);
        seen_ff = 1'b1;
      end
      if (obs_rsp_valid[3]) check("zero_product", 32'(obs_prod), 32'h0);
    end
    check("max_seen", 32'(seen_ff), 32'd1);

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      ra = $urandom; rb = $urandom;
      cycle(4'($urandom), 4'($urandom) | 4'($urandom), ra, rb, 1'b0);
    end
    for (int k = 0; k < 8; k++) cycle(4'h0, 4'hF, 32'h0, 32'h0, 1'b0);

    // Reset with three results in flight: all discarded, requester 0 wins next.
    cycle(4'b0001, 4'hF, 32'h11111111, 32'h22222222, 1'b0);
    cycle(4'b0010, 4'hF, 32'h33333333, 32'h44444444, 1'b0);
    cycle(4'b0100, 4'hF, 32'h55555555, 32'h66666666, 1'b0);
    cycle(4'hF, 4'hF, 32'h0, 32'h0, 1'b1);
    n_retired = 0;
    cycle(4'hF, 4'hF, 32'h07070707, 32'h09090909, 1'b0);
    check("post_rst_census", 32'(obs_census), 32'd0);
    check("post_rst_grant", 32'(obs_req_ready), 32'h1);
    for (int k = 0; k < 8; k++) cycle(4'h0, 4'hF, 32'h0, 32'h0, 1'b0);
    check("post_rst_retired", 32'(n_retired), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
